ddr3_cmd_timer: RTL and testbench

- Timing-enforcement stage directly downstream of the DDR3 command FSM.
- Accepts one command at a time on the ddl_* handshake and holds it off until every DDR3 inter-command constraint is met.
- Drives registered DFI command/address pins and schedules periodic refresh, signalled upstream via ddl_ref_o.
- Single-open-row model: the upstream FSM opens one bank/row at a time and closes it with auto-precharge (RD-A/WR-A).

---
 rtl/ddr3_cmd_timer_pkg.sv | 44 ++++
 rtl/ddr3_refresh_ctr.sv | 59 +++++
 rtl/ddr3_cmd_timer.sv | 191 +++++++++++++++++++
 tb/tb_ddr3_cmd_timer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_cmd_timer_pkg.sv
// Shared command encodings, DFI pin bundle and default DDR3 timing values.
package ddr3_cmd_timer_pkg;

  localparam int unsigned DEF_ROW_BITS = 13;
  localparam int unsigned DEF_TRCD     = 2;
  localparam int unsigned DEF_TRC      = 6;
  localparam int unsigned DEF_TRAS     = 4;
  localparam int unsigned DEF_TRP      = 2;
  localparam int unsigned DEF_TCCD     = 4;
  localparam int unsigned DEF_TWTR     = 4;
  localparam int unsigned DEF_TRTW     = 3;
  localparam int unsigned DEF_TWRAP    = 6;
  localparam int unsigned DEF_TRTP     = 2;
  localparam int unsigned DEF_TRFC     = 11;
  localparam int unsigned DEF_TMOD     = 12;
  localparam int unsigned DEF_TREFI    = 780;
  localparam int unsigned DEF_REF_MAX  = 8;

  // {ras_n, cas_n, we_n} as driven on the DDR3 command pins
  typedef enum logic [2:0] {
    CMD_MODE = 3'b000,
    CMD_REFR = 3'b001,
    CMD_PREC = 3'b010,
    CMD_ACTV = 3'b011,
    CMD_WRIT = 3'b100,
    CMD_READ = 3'b101,
    CMD_ZQCL = 3'b110,
    CMD_NOOP = 3'b111
  } ddr_cmd_e;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } dfi_cmd_t;

  localparam dfi_cmd_t DFI_DESEL = 4'b1111;

  function automatic int unsigned imax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_refresh_ctr.sv
// Refresh interval timer plus owed-refresh debt counter.
module ddr3_refresh_ctr
  import ddr3_cmd_timer_pkg::*;
#(
  parameter int unsigned TREFI   = DEF_TREFI,
  parameter int unsigned REF_MAX = DEF_REF_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic run_i,
  input  logic ref_acc_i,
  output logic ref_owed_o
);

  localparam int unsigned REFI_W = (TREFI > 1) ? $clog2(TREFI) : 1;
  localparam int unsigned DEBT_W = $clog2(REF_MAX + 1);

  logic [REFI_W-1:0] refi_q, refi_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              owed_q, owed_d;
  logic              wrap_c;

  // Interval count while running; debt rises on wrap, falls on REF, both cancel
  always_comb begin
    refi_d = refi_q;
    debt_d = debt_q;
    wrap_c = 1'b0;
    if (run_i) begin
      if (refi_q == REFI_W'(TREFI - 1)) begin
        refi_d = '0;
        wrap_c = 1'b1;
      end else begin
        refi_d = refi_q + REFI_W'(1);
      end
    end
    case ({wrap_c, ref_acc_i})
      2'b10:   if (debt_q != DEBT_W'(REF_MAX)) debt_d = debt_q + DEBT_W'(1);
      2'b01:   if (debt_q != '0) debt_d = debt_q - DEBT_W'(1);
      default: ;
    endcase
    owed_d = (debt_d != '0);
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refi_q <= '0;
      debt_q <= '0;
      owed_q <= 1'b0;
    end else begin
      refi_q <= refi_d;
      debt_q <= debt_d;
      owed_q <= owed_d;
    end
  end

  assign ref_owed_o = owed_q;

endmodule

// File: rtl/ddr3_cmd_timer.sv
// DDR3 inter-command timing gate between the command FSM and the DFI pins.
module ddr3_cmd_timer
  import ddr3_cmd_timer_pkg::*;
#(
  parameter int unsigned DDR_ROW_BITS = DEF_ROW_BITS,
  parameter int unsigned TRCD    = DEF_TRCD,
  parameter int unsigned TRC     = DEF_TRC,
  parameter int unsigned TRAS    = DEF_TRAS,
  parameter int unsigned TRP     = DEF_TRP,
  parameter int unsigned TCCD    = DEF_TCCD,
  parameter int unsigned TWTR    = DEF_TWTR,
  parameter int unsigned TRTW    = DEF_TRTW,
  parameter int unsigned TWRAP   = DEF_TWRAP,
  parameter int unsigned TRTP    = DEF_TRTP,
  parameter int unsigned TRFC    = DEF_TRFC,
  parameter int unsigned TMOD    = DEF_TMOD,
  parameter int unsigned TREFI   = DEF_TREFI,
  parameter int unsigned REF_MAX = DEF_REF_MAX
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_run_i,
  input  logic                    ddl_req_i,
  input  logic                    ddl_seq_i,
  output logic                    ddl_rdy_o,
  output logic                    ddl_ref_o,
  input  logic [2:0]              ddl_cmd_i,
  input  logic [2:0]              ddl_ba_i,
  input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
  output logic                    dfi_cs_n_o,
  output logic                    dfi_ras_n_o,
  output logic                    dfi_cas_n_o,
  output logic                    dfi_we_n_o,
  output logic [2:0]              dfi_ba_o,
  output logic [DDR_ROW_BITS-1:0] dfi_adr_o,
  output logic                    wr_issue_o,
  output logic                    rd_issue_o,
  output logic                    seq_err_o
);

  localparam int unsigned CLOSE_MAX = imax(imax(TWRAP, TRTP), TRAS) + TRP;
  localparam int unsigned TMR_MAX   = imax(imax(imax(TRC, TRCD), imax(TCCD, TWTR)),
                                           imax(imax(TRTW, TRFC), imax(TMOD, CLOSE_MAX)));
  localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned RAS_SLACK = TRC - TRAS;

  typedef logic [TMR_W-1:0] tmr_t;

  function automatic tmr_t dec(input tmr_t t);
    return (t == '0) ? '0 : t - TMR_W'(1);
  endfunction

  tmr_t rc_q, rc_d, rcd_q, rcd_d, ccd_q, ccd_d, wtr_q, wtr_d;
  tmr_t rtw_q, rtw_d, close_q, close_d, blk_q, blk_d;
  tmr_t ras_rem_c, close_rd_c, close_wr_c;

  dfi_cmd_t                dfi_q, dfi_d;
  logic [2:0]              ba_q, ba_d;
  logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
  logic                    wr_q, wr_d, rd_q, rd_d, seq_err_q, seq_err_d;

  ddr_cmd_e cmd_c;
  logic     cmd_ok_c, acc_c, ref_acc_c;

  assign cmd_c = ddr_cmd_e'(ddl_cmd_i);

  // Readiness of the presented command against the running timers
  always_comb begin
    cmd_ok_c = 1'b0;
    case (cmd_c)
      CMD_ACTV: cmd_ok_c = (blk_q == '0) && (rc_q == '0) && (close_q == '0);
      CMD_READ: cmd_ok_c = (blk_q == '0) && (rcd_q == '0) && (ccd_q == '0) && (wtr_q == '0);
      CMD_WRIT: cmd_ok_c = (blk_q == '0) && (rcd_q == '0) && (ccd_q == '0) && (rtw_q == '0);
      CMD_REFR, CMD_PREC,
      CMD_MODE, CMD_ZQCL: cmd_ok_c = (blk_q == '0) && (close_q == '0);
      default:  cmd_ok_c = 1'b1;
    endcase
  end

  assign ddl_rdy_o = ~reset & cmd_ok_c;
  assign acc_c     = ddl_req_i & ddl_rdy_o & (cmd_c != CMD_NOOP);
  assign ref_acc_c = acc_c & (cmd_c == CMD_REFR);

  // Auto-precharge close time: data/tRAS constraint first, then tRP
  always_comb begin
    ras_rem_c  = (rc_q > TMR_W'(RAS_SLACK)) ? rc_q - TMR_W'(RAS_SLACK) : '0;
    close_rd_c = ((ras_rem_c > TMR_W'(TRTP)) ? ras_rem_c : TMR_W'(TRTP)) + TMR_W'(TRP - 1);
    close_wr_c = ((ras_rem_c > TMR_W'(TWRAP)) ? ras_rem_c : TMR_W'(TWRAP)) + TMR_W'(TRP - 1);
  end

  // Next-state: timer reload on issue, otherwise saturating countdown
  always_comb begin
    rc_d      = dec(rc_q);
    rcd_d     = dec(rcd_q);
    ccd_d     = dec(ccd_q);
    wtr_d     = dec(wtr_q);
    rtw_d     = dec(rtw_q);
    close_d   = dec(close_q);
    blk_d     = dec(blk_q);
    dfi_d     = DFI_DESEL;
    ba_d      = ba_q;
    adr_d     = adr_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    seq_err_d = seq_err_q;
    if (acc_c) begin
      dfi_d = dfi_cmd_t'({1'b0, ddl_cmd_i});
      ba_d  = ddl_ba_i;
      adr_d = ddl_adr_i;
      case (cmd_c)
        CMD_ACTV: begin
          rc_d  = TMR_W'(TRC - 1);
          rcd_d = TMR_W'(TRCD - 1);
        end
        CMD_READ: begin
          rd_d  = 1'b1;
          ccd_d = TMR_W'(TCCD - 1);
          rtw_d = TMR_W'(TRTW - 1);
          if (ddl_adr_i[10]) close_d = close_rd_c;
          if (ddl_seq_i == ddl_adr_i[10]) seq_err_d = 1'b1;
        end
        CMD_WRIT: begin
          wr_d  = 1'b1;
          ccd_d = TMR_W'(TCCD - 1);
          wtr_d = TMR_W'(TWTR - 1);
          if (ddl_adr_i[10]) close_d = close_wr_c;
          if (ddl_seq_i == ddl_adr_i[10]) seq_err_d = 1'b1;
        end
        CMD_REFR: blk_d = TMR_W'(TRFC - 1);
        CMD_PREC: blk_d = TMR_W'(TRP - 1);
        CMD_MODE, CMD_ZQCL: blk_d = TMR_W'(TMOD - 1);
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc_q      <= '0;
      rcd_q     <= '0;
      ccd_q     <= '0;
      wtr_q     <= '0;
      rtw_q     <= '0;
      close_q   <= '0;
      blk_q     <= '0;
      dfi_q     <= DFI_DESEL;
      ba_q      <= '0;
      adr_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      rc_q      <= rc_d;
      rcd_q     <= rcd_d;
      ccd_q     <= ccd_d;
      wtr_q     <= wtr_d;
      rtw_q     <= rtw_d;
      close_q   <= close_d;
      blk_q     <= blk_d;
      dfi_q     <= dfi_d;
      ba_q      <= ba_d;
      adr_q     <= adr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      seq_err_q <= seq_err_d;
    end
  end

  ddr3_refresh_ctr #(
    .TREFI   (TREFI),
    .REF_MAX (REF_MAX)
  ) u_refresh_ctr (
    .clock      (clock),
    .reset      (reset),
    .run_i      (cfg_run_i),
    .ref_acc_i  (ref_acc_c),
    .ref_owed_o (ddl_ref_o)
  );

  assign dfi_cs_n_o  = dfi_q.cs_n;
  assign dfi_ras_n_o = dfi_q.ras_n;
  assign dfi_cas_n_o = dfi_q.cas_n;
  assign dfi_we_n_o  = dfi_q.we_n;
  assign dfi_ba_o    = ba_q;
  assign dfi_adr_o   = adr_q;
  assign wr_issue_o  = wr_q;
  assign rd_issue_o  = rd_q;
  assign seq_err_o   = seq_err_q;

endmodule

// File: tb/tb_ddr3_cmd_timer.sv
// Scoreboard bench for ddr3_cmd_timer: accept spacing, DFI pins, refresh debt, reset.
module tb_ddr3_cmd_timer;
  import ddr3_cmd_timer_pkg::*;

  localparam int unsigned RB = 13;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_run_i, ddl_req_i, ddl_seq_i;
  logic          ddl_rdy_o, ddl_ref_o;
  logic [2:0]    ddl_cmd_i, ddl_ba_i;
  logic [RB-1:0] ddl_adr_i;
  logic          dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o;
  logic [2:0]    dfi_ba_o;
  logic [RB-1:0] dfi_adr_o;
  logic          wr_issue_o, rd_issue_o, seq_err_o;

  ddr3_cmd_timer dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_run_i   (cfg_run_i),
    .ddl_req_i   (ddl_req_i),
    .ddl_seq_i   (ddl_seq_i),
    .ddl_rdy_o   (ddl_rdy_o),
    .ddl_ref_o   (ddl_ref_o),
    .ddl_cmd_i   (ddl_cmd_i),
    .ddl_ba_i    (ddl_ba_i),
    .ddl_adr_i   (ddl_adr_i),
    .dfi_cs_n_o  (dfi_cs_n_o),
    .dfi_ras_n_o (dfi_ras_n_o),
    .dfi_cas_n_o (dfi_cas_n_o),
    .dfi_we_n_o  (dfi_we_n_o),
    .dfi_ba_o    (dfi_ba_o),
    .dfi_adr_o   (dfi_adr_o),
    .wr_issue_o  (wr_issue_o),
    .rd_issue_o  (rd_issue_o),
    .seq_err_o   (seq_err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    cmd;
    logic [2:0]    ba;
    logic [RB-1:0] adr;
    longint        at;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_acc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every issued command must match the oldest expectation, one cycle after accept
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (dfi_cs_n_o == 1'b0) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: cmd=%b ba=%0d adr=%h at cycle %0d, expected no issue",
                   {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_ba_o, dfi_adr_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          if ({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} != mon_e.cmd || dfi_ba_o != mon_e.ba ||
              dfi_adr_o != mon_e.adr || cyc != mon_e.at ||
              wr_issue_o != (mon_e.cmd == CMD_WRIT) || rd_issue_o != (mon_e.cmd == CMD_READ)) begin
            errors++;
            $display("FAIL dfi_issue: got cmd=%b ba=%0d adr=%h cyc=%0d wr=%b rd=%b, expected cmd=%b ba=%0d adr=%h cyc=%0d",
                     {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_ba_o, dfi_adr_o, cyc,
                     wr_issue_o, rd_issue_o, mon_e.cmd, mon_e.ba, mon_e.adr, mon_e.at);
          end
        end
      end else if ({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} != 3'b111 || wr_issue_o || rd_issue_o) begin
        errors++;
        $display("FAIL idle_pins: got ras/cas/we=%b wr=%b rd=%b at cycle %0d, expected 111/0/0",
                 {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, wr_issue_o, rd_issue_o, cyc);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Present a command, wait for ready, check spacing from previous accept (gap 0 = unchecked)
  task automatic issue(input logic [2:0] cmd, input logic [2:0] ba, input logic [RB-1:0] adr,
                       input logic seq, input int gap, input string name);
    int   waited;
    bit   ok;
    exp_t e;
    ddl_cmd_i = cmd;
    ddl_ba_i  = ba;
    ddl_adr_i = adr;
    ddl_seq_i = seq;
    ddl_req_i = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 20000) begin
      @(negedge clock);
      if (ddl_rdy_o) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ready after %0d cycles, expected accept", name, waited);
      ddl_req_i = 1'b0;
      ddl_cmd_i = CMD_NOOP;
      return;
    end
    if (gap > 0) chk({name, "_gap"}, cyc - last_acc, gap);
    last_acc = cyc;
    e.cmd = cmd;
    e.ba  = ba;
    e.adr = adr;
    e.at  = cyc + 1;
    sb.push_back(e);
    @(posedge clock);
    #1;
    ddl_req_i = 1'b0;
    ddl_cmd_i = CMD_NOOP;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_run_i = 1'b0;
    ddl_req_i = 1'b0;
    ddl_seq_i = 1'b0;
    ddl_cmd_i = CMD_NOOP;
    ddl_ba_i  = '0;
    ddl_adr_i = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rdy", ddl_rdy_o, 0);
    chk("rst_pins", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, 4'hf);
    chk("rst_ba_adr", {dfi_ba_o, dfi_adr_o}, 0);
    chk("rst_strobes", {wr_issue_o, rd_issue_o}, 0);
    chk("rst_seq_err", seq_err_o, 0);
    chk("rst_ref", ddl_ref_o, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_noop_rdy", ddl_rdy_o, 1);

    // Row cycle with writes and write auto-precharge
    issue(CMD_ACTV, 3'd3, 13'h0123, 1'b0, 0, "act1");
    issue(CMD_WRIT, 3'd3, 13'h0010, 1'b1, 2, "wr_trcd");
    issue(CMD_WRIT, 3'd3, 13'h0018, 1'b1, 4, "wr_tccd");
    issue(CMD_WRIT, 3'd3, 13'h0420, 1'b0, 4, "wra_tccd");
    issue(CMD_ACTV, 3'd5, 13'h1abc, 1'b0, 8, "act_after_wra");
    // Early read auto-precharge: tRAS-limited close coincides with tRC
    issue(CMD_READ, 3'd5, 13'h0408, 1'b0, 2, "rda_trcd");
    issue(CMD_ACTV, 3'd1, 13'h0777, 1'b0, 4, "act_after_rda");
    // Read/write turnarounds
    issue(CMD_WRIT, 3'd1, 13'h0020, 1'b1, 2, "wr2");
    issue(CMD_READ, 3'd1, 13'h0028, 1'b1, 4, "rd_twtr");
    issue(CMD_WRIT, 3'd1, 13'h0030, 1'b1, 4, "wr_trtw");
    issue(CMD_READ, 3'd1, 13'h0438, 1'b0, 4, "rda_twtr");
    issue(CMD_ACTV, 3'd2, 13'h0001, 1'b0, 4, "act_trtp");
    // Blocking commands
    issue(CMD_PREC, 3'd2, 13'h0400, 1'b0, 1, "pre");
    issue(CMD_MODE, 3'd0, 13'h0520, 1'b0, 2, "mrs_trp");
    issue(CMD_REFR, 3'd0, 13'h0000, 1'b0, 12, "ref_tmod");
    issue(CMD_ACTV, 3'd4, 13'h0042, 1'b0, 11, "act_trfc");
    issue(CMD_ZQCL, 3'd0, 13'h0400, 1'b0, 1, "zqcl");
    issue(CMD_ACTV, 3'd4, 13'h0043, 1'b0, 12, "act_zq_tmod");

    // Single refresh interval
    cfg_run_i = 1'b1;
    repeat (779) @(posedge clock);
    #1;
    chk("ref_before_wrap", ddl_ref_o, 0);
    @(posedge clock);
    #1;
    chk("ref_after_wrap", ddl_ref_o, 1);
    cfg_run_i = 1'b0;
    issue(CMD_REFR, 3'd0, 13'h0000, 1'b0, 0, "ref_owed");
    chk("ref_cleared", ddl_ref_o, 0);
    ddl_req_i = 1'b1;
    ddl_cmd_i = CMD_NOOP;
    #1;
    chk("noop_rdy_in_trfc", ddl_rdy_o, 1);
    ddl_cmd_i = CMD_ZQCL;
    #1;
    chk("zq_blocked_in_trfc", ddl_rdy_o, 0);
    issue(CMD_ZQCL, 3'd0, 13'h0400, 1'b0, 11, "zq_after_ref");

    // Nine intervals saturate debt at eight
    cfg_run_i = 1'b1;
    repeat (9 * 780) @(posedge clock);
    #1;
    cfg_run_i = 1'b0;
    chk("ref_sat_owed", ddl_ref_o, 1);
    for (int i = 0; i < 8; i++) begin
      issue(CMD_REFR, 3'd0, 13'h0000, 1'b0, (i == 0) ? 0 : 11, "ref_sat");
      chk("ref_owed_after_ref", ddl_ref_o, (i < 7) ? 1 : 0);
    end

    // Sequence-hint mismatch is sticky
    chk("seq_err_clean", seq_err_o, 0);
    issue(CMD_ACTV, 3'd6, 13'h0100, 1'b0, 11, "act_after_ref");
    issue(CMD_READ, 3'd6, 13'h0040, 1'b1, 2, "rd_seq_ok");
    chk("seq_err_still_clean", seq_err_o, 0);
    issue(CMD_READ, 3'd6, 13'h0448, 1'b1, 4, "rda_seq_bad");
    chk("seq_err_set", seq_err_o, 1);
    issue(CMD_ACTV, 3'd6, 13'h0200, 1'b0, 4, "act_after_rda2");
    repeat (3) @(posedge clock);
    #1;
    chk("seq_err_sticky", seq_err_o, 1);

    // Reset in the middle of a write burst
    issue(CMD_WRIT, 3'd6, 13'h0010, 1'b1, 0, "wr_burst");
    ddl_cmd_i = CMD_WRIT;
    ddl_ba_i  = 3'd6;
    ddl_adr_i = 13'h0018;
    ddl_seq_i = 1'b1;
    ddl_req_i = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", ddl_rdy_o, 0);
    chk("mid_rst_pins", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, 4'hf);
    chk("mid_rst_ba_adr", {dfi_ba_o, dfi_adr_o}, 0);
    chk("mid_rst_strobes", {wr_issue_o, rd_issue_o}, 0);
    chk("mid_rst_seq_err", seq_err_o, 0);
    ddl_req_i = 1'b0;
    ddl_cmd_i = CMD_NOOP;
    @(posedge clock);
    #1;
    reset = 1'b0;
    issue(CMD_ACTV, 3'd7, 13'h0055, 1'b0, 0, "act_post_rst");
    issue(CMD_READ, 3'd7, 13'h0008, 1'b1, 2, "rd_post_rst");
    repeat (3) @(posedge clock);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
